// File: rtl/result_logger_pkg.sv
// result_logger_pkg: shared types and constants for the result change logger.
// Provides the FSM state type, the logged entry record {value, ts} and the
// drop counter saturation value.
package result_logger_pkg;

    localparam int WIDTH_DEF = 6;
    localparam int TS_W_DEF  = 16;
    localparam logic [7:0] DROP_MAX = 8'd255;

    typedef enum logic [1:0] {IDLE, PRIME, RUN} state_t;

    typedef struct packed {
        logic [WIDTH_DEF-1:0] value;
        logic [TS_W_DEF-1:0]  ts;
    } entry_t;

endpackage

// File: rtl/result_change_logger_sync_fifo.sv
// sync_fifo: first-in first-out store of entry_t records.
// Ports: clk, rst_n (async active-low), push/push_data, pop/pop_data,
// empty, full, level (occupancy 0..DEPTH).
// A push while full is accepted only if a pop happens in the same cycle.
// pop_data reads zero while empty.
module sync_fifo
    import result_logger_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  entry_t                   push_data,
    input  logic                     pop,
    output entry_t                   pop_data,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

    entry_t        mem_q [DEPTH];
    logic [AW:0]   wptr_q, wptr_d, rptr_q, rptr_d;
    logic          do_push, do_pop;

    // Pointers carry one extra wrap bit, so their difference is the occupancy.
    always_comb begin
        empty    = wptr_q == rptr_q;
        level    = wptr_q - rptr_q;
        full     = level == FULL_LVL;
        do_pop   = pop && !empty;
        do_push  = push && (!full || do_pop);
        wptr_d   = wptr_q + {{AW{1'b0}}, do_push};
        rptr_d   = rptr_q + {{AW{1'b0}}, do_pop};
        pop_data = empty ? '0 : mem_q[rptr_q[AW-1:0]];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wptr_q[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/result_change_logger.sv
// result_change_logger: samples the logic-stage result vector and logs each
// change as a {value, timestamp} entry into a FIFO drained by valid/ready.
// Ports: clk, rst_n (async active-low), en (sampling enable), clear (clears
// overflow/drop_count), y_in (sampled vector), out_valid/out_ready/out_value/
// out_ts (FIFO head), level (occupancy), overflow (sticky drop flag),
// drop_count (saturating drop counter).
// Build option RESULT_LOGGER_FILTER_EN: a change is logged only once the new
// value has been seen on two consecutive RUN samples, with the first one's ts.
module result_change_logger
    import result_logger_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int DEPTH = 8,
    parameter int TS_W  = TS_W_DEF
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     en,
    input  logic                     clear,
    input  logic [WIDTH-1:0]         y_in,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH-1:0]         out_value,
    output logic [TS_W-1:0]          out_ts,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     overflow,
    output logic [7:0]               drop_count
);

    state_t           state_q, state_d;
    logic [TS_W-1:0]  ts_q, ts_d;
    logic [WIDTH-1:0] prev_q, prev_d;
    logic             overflow_q, overflow_d;
    logic [7:0]       drop_count_q, drop_count_d;
    logic             push, pop, drop, empty, full;
    entry_t           push_entry, head;
`ifdef RESULT_LOGGER_FILTER_EN
    logic [WIDTH-1:0] cand_q, cand_d;
    logic [TS_W-1:0]  cand_ts_q, cand_ts_d;
    logic             cand_vld_q, cand_vld_d;
`endif

    always_comb begin
        state_d    = state_q;
        prev_d     = prev_q;
        push       = 1'b0;
        push_entry = '0;
        ts_d       = en ? ts_q + TS_W'(1) : ts_q;
`ifdef RESULT_LOGGER_FILTER_EN
        cand_d     = cand_q;
        cand_ts_d  = cand_ts_q;
        cand_vld_d = 1'b0;
`endif
        if (!en) begin
            state_d = IDLE;
        end else if (state_q == IDLE) begin
            state_d = PRIME;
        end else if (state_q == PRIME) begin
            state_d = RUN;
            prev_d  = y_in;
        end else if (y_in != prev_q) begin
`ifdef RESULT_LOGGER_FILTER_EN
            // Second consecutive sample of the same new value confirms it.
            if (cand_vld_q && y_in == cand_q) begin
                push       = 1'b1;
                push_entry = '{value: cand_q, ts: cand_ts_q};
                prev_d     = y_in;
            end else begin
                cand_d     = y_in;
                cand_ts_d  = ts_q;
                cand_vld_d = 1'b1;
            end
`else
            push       = 1'b1;
            push_entry = '{value: y_in, ts: ts_q};
            prev_d     = y_in;
`endif
        end
        pop          = out_valid && out_ready;
        drop         = push && full && !pop;
        overflow_d   = clear ? 1'b0 : (overflow_q || drop);
        drop_count_d = clear ? 8'd0 :
                       (drop && drop_count_q != DROP_MAX) ? drop_count_q + 8'd1 : drop_count_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            ts_q         <= '0;
            prev_q       <= '0;
            overflow_q   <= 1'b0;
            drop_count_q <= '0;
`ifdef RESULT_LOGGER_FILTER_EN
            cand_q       <= '0;
            cand_ts_q    <= '0;
            cand_vld_q   <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            ts_q         <= ts_d;
            prev_q       <= prev_d;
            overflow_q   <= overflow_d;
            drop_count_q <= drop_count_d;
`ifdef RESULT_LOGGER_FILTER_EN
            cand_q       <= cand_d;
            cand_ts_q    <= cand_ts_d;
            cand_vld_q   <= cand_vld_d;
`endif
        end
    end

    sync_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data (push_entry),
        .pop       (out_ready),
        .pop_data  (head),
        .empty     (empty),
        .full      (full),
        .level     (level)
    );

    assign out_valid  = !empty;
    assign out_value  = head.value;
    assign out_ts     = head.ts;
    assign overflow   = overflow_q;
    assign drop_count = drop_count_q;

endmodule

// File: tb/tb_result_change_logger.sv
// tb_result_change_logger: directed, table-driven check of result_change_logger.
module tb_result_change_logger;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic        clear = 1'b0;
    logic        out_ready = 1'b0;
    logic [5:0]  y_in = '0;
    logic        out_valid;
    logic [5:0]  out_value;
    logic [15:0] out_ts;
    logic [3:0]  level;
    logic        overflow;
    logic [7:0]  drop_count;

    int total = 0;
    int passed = 0;

    typedef struct {
        logic        en, clr;
        logic [5:0]  y;
        logic        rdy;
        logic        vld;
        logic [5:0]  val;
        logic [15:0] ts;
        logic [3:0]  lvl;
        logic        ovf;
        logic [7:0]  drop;
    } vec_t;

    vec_t vecs[$];

    result_change_logger dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .clear      (clear),
        .y_in       (y_in),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_value  (out_value),
        .out_ts     (out_ts),
        .level      (level),
        .overflow   (overflow),
        .drop_count (drop_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic step(input logic e, input logic c, input logic [5:0] y, input logic r);
        en = e;
        clear = c;
        y_in = y;
        out_ready = r;
        @(posedge clk);
        #1;
    endtask

    function automatic void add(input logic e, input logic c, input logic [5:0] y, input logic r,
                                input logic vld, input logic [5:0] val, input logic [15:0] ts,
                                input logic [3:0] lvl, input logic ovf, input logic [7:0] drop);
        vecs.push_back('{e, c, y, r, vld, val, ts, lvl, ovf, drop});
    endfunction

    initial begin
        #12;
        chk("reset out_valid", 32'(out_valid), 0);
        chk("reset out_value", 32'(out_value), 0);
        chk("reset out_ts", 32'(out_ts), 0);
        chk("reset level", 32'(level), 0);
        chk("reset overflow", 32'(overflow), 0);
        chk("reset drop_count", 32'(drop_count), 0);
        rst_n = 1'b1;

`ifndef RESULT_LOGGER_FILTER_EN
        // Row r samples y_in while the timestamp equals r.
        for (int i = 0; i < 5; i++) add(1, 0, 6'h00, 1, 0, 0, 0, 0, 0, 0);
        add(1, 0, 6'h15, 1, 1, 6'h15, 5, 1, 0, 0);
        add(1, 0, 6'h15, 1, 0, 0, 0, 0, 0, 0);
        for (int k = 1; k <= 10; k++)
            add(1, 0, 6'(k), 0, 1, 6'h01, 7, 4'(k > 8 ? 8 : k), k > 8, 8'(k > 8 ? k - 8 : 0));
        add(1, 0, 6'd11, 1, 1, 6'd2, 8, 8, 1, 2);
        add(1, 1, 6'd12, 0, 1, 6'd2, 8, 8, 0, 0);
        add(1, 0, 6'd12, 0, 1, 6'd2, 8, 8, 0, 0);
        begin
            logic [5:0]  dv [7] = '{3, 4, 5, 6, 7, 8, 11};
            logic [15:0] dt [7] = '{9, 10, 11, 12, 13, 14, 17};
            for (int i = 0; i < 7; i++) add(1, 0, 6'd12, 1, 1, dv[i], dt[i], 4'(7 - i), 0, 0);
        end
        add(1, 0, 6'd12, 1, 0, 0, 0, 0, 0, 0);

        foreach (vecs[i]) begin
            step(vecs[i].en, vecs[i].clr, vecs[i].y, vecs[i].rdy);
            chk($sformatf("row%0d out_valid", i), 32'(out_valid), 32'(vecs[i].vld));
            chk($sformatf("row%0d out_value", i), 32'(out_value), 32'(vecs[i].val));
            chk($sformatf("row%0d out_ts", i), 32'(out_ts), 32'(vecs[i].ts));
            chk($sformatf("row%0d level", i), 32'(level), 32'(vecs[i].lvl));
            chk($sformatf("row%0d overflow", i), 32'(overflow), 32'(vecs[i].ovf));
            chk($sformatf("row%0d drop_count", i), 32'(drop_count), 32'(vecs[i].drop));
        end
`else
        step(1, 0, 6'h00, 0);
        step(1, 0, 6'h00, 0);
        step(1, 0, 6'h00, 0);
        step(1, 0, 6'h3F, 0);
        chk("filt glitch level a", 32'(level), 0);
        step(1, 0, 6'h00, 0);
        chk("filt glitch level b", 32'(level), 0);
        step(1, 0, 6'h00, 0);
        chk("filt glitch level c", 32'(out_valid), 0);
        step(1, 0, 6'h3F, 0);
        chk("filt first hold level", 32'(level), 0);
        step(1, 0, 6'h3F, 0);
        chk("filt hold out_valid", 32'(out_valid), 1);
        chk("filt hold out_value", 32'(out_value), 32'h3F);
        chk("filt hold out_ts", 32'(out_ts), 6);
        chk("filt hold level", 32'(level), 1);
        step(1, 0, 6'h3F, 1);
        chk("filt pop out_valid", 32'(out_valid), 0);
`endif

        // Each value held two cycles so the sequence logs five entries in either build.
        for (int i = 0; i < 5; i++) begin
            step(1, 0, 6'(20 + i), 0);
            step(1, 0, 6'(20 + i), 0);
        end
        chk("prefill level", 32'(level), 5);
        chk("prefill out_value", 32'(out_value), 20);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async rst level", 32'(level), 0);
        chk("async rst out_valid", 32'(out_valid), 0);
        chk("async rst out_value", 32'(out_value), 0);
        chk("async rst out_ts", 32'(out_ts), 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
